// File: rtl/set_frame_pkg.sv
// set_frame_pkg: shared state encoding and default framing constants
package set_frame_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_N_FLAGS = 2;
    localparam logic [15:0] FLAG_CH0 = 16'hFE6B;
    localparam logic [15:0] FLAG_CH1 = 16'h2840;
endpackage

// File: rtl/set_frame_sync.sv
// set_frame_sync: two-flop synchroniser plus history flop, one pulse per rising edge of async_i
module set_frame_sync (
    input  logic signal_clk,
    input  logic signal_rst_n,
    input  logic async_i,
    output logic pulse_o
);
    logic [2:0] sh_q;
    // shift the async level through two sync stages and one history stage
    always_ff @(posedge signal_clk) begin
        if (!signal_rst_n) sh_q <= '0;
        else sh_q <= {sh_q[1:0], async_i};
    end
    assign pulse_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/set_frame.sv
// set_frame: captures a count word plus flag words on a write strobe and streams them out with valid/ready
module set_frame
    import set_frame_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_FLAGS = DEF_N_FLAGS,
    parameter logic [N_FLAGS*DATA_W-1:0] FLAG_PAT = {FLAG_CH1, FLAG_CH0}
) (
    input  logic               signal_clk,
    input  logic               signal_rst_n,
    input  logic               signal_w,
    input  logic               signal_d,
    input  logic [N_FLAGS-1:0] signal_f,
    input  logic [DATA_W-1:0]  count_in,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_done,
    output logic               overrun,
    input  logic               clr_ovr
);
    localparam int IDX_W = $clog2(N_FLAGS + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FLAGS);
    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] words_q [N_FLAGS+1];
    logic [DATA_W-1:0] words_d [N_FLAGS+1];
    logic done_q, done_d, ovr_q, ovr_d, req;

    set_frame_sync u_sync (
        .signal_clk  (signal_clk),
        .signal_rst_n(signal_rst_n),
        .async_i     (signal_w),
        .pulse_o     (req)
    );

    // register state, index, captured words and status flags
    always_ff @(posedge signal_clk) begin
        if (!signal_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            words_q <= '{default: '0};
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // capture a frame on request in IDLE, step through words on handshakes in SEND
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        done_d  = 1'b0;
        ovr_d   = (ovr_q & ~clr_ovr) | (req & (state_q == SEND));
        if (state_q == IDLE) begin
            if (req) begin
                state_d    = SEND;
                idx_d      = '0;
                words_d[0] = signal_d ? count_in : '0;
                for (int i = 0; i < N_FLAGS; i++)
                    words_d[i+1] = signal_f[i] ? FLAG_PAT[i*DATA_W +: DATA_W] : '0;
            end
        end else if (out_ready) begin
            if (idx_q == LAST) begin
                state_d = IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    assign out_valid  = (state_q == SEND);
    assign out_data   = (state_q == SEND) ? words_q[idx_q] : '0;
    assign frame_done = done_q;
    assign overrun    = ovr_q;
endmodule
